uart_tx_bus: RTL
================

Name: uart_tx_bus

Overview:
- UART transmitter for the MVM output path.
- Accepts one wide result bus (R×W_Y_OUT bits) per valid/ready handshake and splits it into BITS_PER_WORD-bit words, least-significant word first.
- Sends each word as a fixed-length UART packet on a single tx line.
- Sits between the MVM result register and the top-level uo_out[0] pin. It is the TX counterpart of the system's UART receiver.

Parameters:
- CLOCKS_PER_PULSE, 16, clock cycles per UART bit.
- BITS_PER_WORD, 8, data bits per packet.
- PACKET_SIZE, BITS_PER_WORD+5, total bits per packet: 1 start, BITS_PER_WORD data, remainder stop/padding. Must be ≥ BITS_PER_WORD+2.
- W_BUS, 16, width of s_data. Must be a multiple of BITS_PER_WORD.
- N_WORDS, W_BUS/BITS_PER_WORD, words per frame (derived, localparam).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- s_valid  in  1  frame available on s_data
- s_ready  out  1  block can accept a frame
- s_data  in  W_BUS  frame; word i = s_data[i*BITS_PER_WORD +: BITS_PER_WORD]
- tx  out  1  serial line, idle-high
- busy  out  1  frame transmission in progress

Behaviour:
- Reset (async, rst=1): state=IDLE; tx=1; s_ready=1; busy=0; all counters=0; shift register=0. Any in-flight frame is abandoned. tx returns to 1 immediately, without waiting for a clock edge.
- State machine:
  - IDLE: s_ready=1, tx=1. When s_valid&&s_ready at a rising edge, latch s_data into the frame register, clear word, bit and clock counters, and go to SEND.
  - SEND: s_ready=0, busy=1.
  - Bit index b of word w is driven for exactly CLOCKS_PER_PULSE cycles:
    - b=0: tx=0 (start bit).
    - b=1..BITS_PER_WORD: tx = word_w[b-1] (LSB first).
    - b>BITS_PER_WORD: tx=1 (stop/padding).
  - After the last bit of word w<N_WORDS-1, the start bit of word w+1 follows on the next cycle, with no gap.
  - After the last bit of word N_WORDS-1, go to IDLE. IDLE lasts at least one cycle, which only extends padding.
- Timing:
  - tx is registered.
  - Start bit appears on the cycle after the accepting edge (latency 1).
  - Frame duration = N_WORDS*PACKET_SIZE*CLOCKS_PER_PULSE cycles.
- Counters:
  - Clock counter: width $clog2(CLOCKS_PER_PULSE), wraps at CLOCKS_PER_PULSE-1.
  - Bit counter: width $clog2(PACKET_SIZE), wraps at PACKET_SIZE-1.
  - Word counter: width $clog2(N_WORDS)+1. No overflow is possible.
- s_data changes while in SEND are ignored because the frame is latched at acceptance.
- s_valid held high continuously: the next frame is accepted in the IDLE cycle, and frames stream back-to-back separated by one idle-high cycle.
- N_WORDS=1 is legal and gives a single-packet frame.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - Bit index BITS_PER_WORD+1 carries even parity (XOR of the word's data bits).
  - Remaining bits stay 1.
  - PACKET_SIZE must be ≥ BITS_PER_WORD+3 (elaboration-time assertion).
  - Frame duration is unchanged.
- Undefined: no parity; all post-data bits are 1.

Decomposition:
- Package uart_pkg holds:
  - Default constants (CLOCKS_PER_PULSE, BITS_PER_WORD, PACKET_SIZE).
  - The tx state enum {IDLE, SEND}.
  - A function for even parity of a word.
- One natural sub-module, uart_tx_word:
  - Serializes a single word with its own clock and bit counters.
  - Interface: start pulse, word input, done pulse on the final cycle of the last bit.
- uart_tx_bus owns the frame register, word counter, handshake and FSM.

Test Plan:
- Reset: assert rst mid-frame at an arbitrary cycle → tx=1, s_ready=1, busy=0 immediately. After release, no residual bits appear on tx.
- Single frame (defaults, W_BUS=16): s_data=16'hA53C with a one-cycle s_valid.
  - Sampling mid-bit decodes 0x3C then 0xA5.
  - Each packet shows start=0 and 4 ones after the data.
  - s_ready stays low for 416 cycles.
- Back-to-back: hold s_valid=1 over frames 16'h00FF and 16'h8001 → 0xFF, 0x00, 0x01, 0x80 received in order, with exactly one idle cycle between frames.
- Handshake hold-off: s_valid asserted during SEND with changing s_data → nothing is accepted until IDLE. The transmitted frame equals the value latched at acceptance.
- Timing: count cycles from the accepting edge to the tx falling edge = 1. Each bit lasts exactly 16 cycles.
- Parity build: with UART_TX_PARITY_EN, word 0x3C (four ones) gives parity bit 0 and word 0x07 gives 1. Packet length stays 13 bits.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, state type and helpers for the UART TX path.
//
// Contents:
//   UART_CLOCKS_PER_PULSE  default clock cycles per UART bit
//   UART_BITS_PER_WORD     default data bits per packet
//   UART_PACKET_SIZE       default total bits per packet (start + data + stop/pad)
//   tx_state_e             frame-level FSM states {IDLE, SEND}
//   even_parity()          XOR reduction of a (zero-extended) word
//
// Optional feature macro used by the TX path: UART_TX_PARITY_EN.
package uart_pkg;

    localparam int unsigned UART_CLOCKS_PER_PULSE = 16;
    localparam int unsigned UART_BITS_PER_WORD    = 8;
    localparam int unsigned UART_PACKET_SIZE      = UART_BITS_PER_WORD + 5;

    // Upper bound on word width accepted by even_parity(); callers zero-extend.
    localparam int unsigned UART_MAX_WORD_BITS = 64;

    typedef enum logic [0:0] {
        IDLE,
        SEND
    } tx_state_e;

    // Even parity: 1 when the word holds an odd number of ones.
    function automatic logic even_parity(input logic [UART_MAX_WORD_BITS-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/uart_tx_word.sv
// uart_tx_word: serializes one word as a fixed-length UART packet.
//
// A start pulse loads the word and restarts the clock and bit counters; the
// packet begins on the following cycle. Bit 0 is the start bit (0), bits
// 1..BITS_PER_WORD carry the data LSB first, and the remaining bits are 1.
// With UART_TX_PARITY_EN defined, bit BITS_PER_WORD+1 carries even parity.
// A start pulse in the same cycle as done chains the next packet with no gap.
//
// Ports:
//   clk     clock
//   rst     asynchronous reset, active-high
//   start   load word and begin a packet on the next cycle
//   word    data word, sampled when start is high
//   active  a packet is being serialized
//   tx_bit  unregistered line value for the current bit (1 when inactive)
//   done    high on the final cycle of the last bit of the packet
module uart_tx_word
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_PULSE = UART_CLOCKS_PER_PULSE,
    parameter int unsigned BITS_PER_WORD    = UART_BITS_PER_WORD,
    parameter int unsigned PACKET_SIZE      = UART_PACKET_SIZE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [BITS_PER_WORD-1:0] word,
    output logic                     active,
    output logic                     tx_bit,
    output logic                     done
);

    localparam int unsigned CW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int unsigned BW = $clog2(PACKET_SIZE);

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(PACKET_SIZE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(BITS_PER_WORD);

    if (PACKET_SIZE < BITS_PER_WORD + 2) begin : g_bad_packet_size
        $error("uart_tx_word: PACKET_SIZE must be at least BITS_PER_WORD+2");
    end

    if (BITS_PER_WORD > UART_MAX_WORD_BITS) begin : g_bad_word_width
        $error("uart_tx_word: BITS_PER_WORD exceeds UART_MAX_WORD_BITS");
    end

`ifdef UART_TX_PARITY_EN
    localparam logic [BW-1:0] PAR_IDX = BW'(BITS_PER_WORD + 1);

    if (PACKET_SIZE < BITS_PER_WORD + 3) begin : g_bad_parity_size
        $error("uart_tx_word: parity needs PACKET_SIZE of at least BITS_PER_WORD+3");
    end
`endif

    logic                     active_q, active_d;
    logic [CW-1:0]            clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
    logic [BITS_PER_WORD-1:0] shift_q, shift_d;
    logic                     clk_wrap;
    logic                     bit_wrap;
`ifdef UART_TX_PARITY_EN
    logic                     par_q, par_d;
`endif

    assign clk_wrap = (clk_cnt_q == CLK_LAST);
    assign bit_wrap = (bit_cnt_q == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q  <= 1'b0;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            active_q  <= active_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    always_comb begin
        active_d  = active_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        if (start) begin
            active_d  = 1'b1;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            shift_d   = word;
`ifdef UART_TX_PARITY_EN
            par_d     = even_parity(UART_MAX_WORD_BITS'(word));
`endif
        end else if (active_q) begin
            if (clk_wrap) begin
                clk_cnt_d = '0;
                if (bit_wrap) begin
                    active_d  = 1'b0;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                // The data bit on the line is always shift_q[0]; advance only
                // when a data bit finishes so the start bit leaves it intact.
                if (bit_cnt_q != '0 && bit_cnt_q <= DATA_LAST) begin
                    shift_d = shift_q >> 1;
                end
            end else begin
                clk_cnt_d = clk_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        tx_bit = 1'b1;
        if (active_q) begin
            if (bit_cnt_q == '0) begin
                tx_bit = 1'b0;
            end else if (bit_cnt_q <= DATA_LAST) begin
                tx_bit = shift_q[0];
            end
`ifdef UART_TX_PARITY_EN
            else if (bit_cnt_q == PAR_IDX) begin
                tx_bit = par_q;
            end
`endif
        end
    end

    assign active = active_q;
    assign done   = active_q && clk_wrap && bit_wrap;

endmodule

// File: rtl/uart_tx_bus.sv
// uart_tx_bus: UART transmitter for the MVM output path.
//
// Accepts one W_BUS-bit frame per valid/ready handshake, splits it into
// BITS_PER_WORD-bit words (least-significant word first) and sends each word
// as a PACKET_SIZE-bit UART packet on tx. Packets within a frame are
// back-to-back; frames are separated by at least one idle-high cycle.
// Optional even parity bit when UART_TX_PARITY_EN is defined (see uart_tx_word).
//
// Ports:
//   clk      clock
//   rst      asynchronous reset, active-high; abandons any in-flight frame
//   s_valid  frame available on s_data
//   s_ready  block can accept a frame (high only in IDLE)
//   s_data   frame; word i = s_data[i*BITS_PER_WORD +: BITS_PER_WORD]
//   tx       registered serial line, idle-high
//   busy     frame transmission in progress
module uart_tx_bus
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_PULSE = UART_CLOCKS_PER_PULSE,
    parameter int unsigned BITS_PER_WORD    = UART_BITS_PER_WORD,
    parameter int unsigned PACKET_SIZE      = BITS_PER_WORD + 5,
    parameter int unsigned W_BUS            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W_BUS-1:0] s_data,
    output logic             tx,
    output logic             busy
);

    localparam int unsigned N_WORDS = W_BUS / BITS_PER_WORD;
    localparam int unsigned WW      = $clog2(N_WORDS) + 1;

    localparam logic [WW-1:0] WORD_LAST = WW'(N_WORDS - 1);

    if (W_BUS % BITS_PER_WORD != 0 || N_WORDS == 0) begin : g_bad_bus_width
        $error("uart_tx_bus: W_BUS must be a non-zero multiple of BITS_PER_WORD");
    end

    tx_state_e                state_q, state_d;
    logic [W_BUS-1:0]         frame_q, frame_d;
    logic [WW-1:0]            word_q, word_d;
    logic [WW-1:0]            word_sel;
    logic                     tx_q;
    logic                     accept;
    logic                     last_word;
    logic                     word_start;
    logic [BITS_PER_WORD-1:0] word_in;
    logic                     word_active;
    logic                     word_bit;
    logic                     word_done;

    assign accept    = s_valid && (state_q == IDLE);
    assign last_word = (word_q == WORD_LAST);
    // Clamp so the part-select below never reaches past the frame register.
    assign word_sel  = last_word ? word_q : word_q + 1'b1;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = SEND;
            SEND: if (word_done && last_word) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            IDLE: s_ready = 1'b1;
            SEND: busy    = 1'b1;
            default: s_ready = 1'b0;
        endcase
    end

    // Frame register, word counter and word-serializer start control. The
    // first word comes straight from s_data so its packet starts one cycle
    // after the accepting edge; later words come from the latched frame.
    always_comb begin
        frame_d    = frame_q;
        word_d     = word_q;
        word_start = 1'b0;
        word_in    = frame_q[word_sel*BITS_PER_WORD +: BITS_PER_WORD];
        if (accept) begin
            frame_d    = s_data;
            word_d     = '0;
            word_start = 1'b1;
            word_in    = s_data[BITS_PER_WORD-1:0];
        end else if (state_q == SEND && word_done && !last_word) begin
            word_d     = word_q + 1'b1;
            word_start = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
            word_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            frame_q <= frame_d;
            word_q  <= word_d;
            tx_q    <= word_bit;
        end
    end

    uart_tx_word #(
        .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
        .BITS_PER_WORD   (BITS_PER_WORD),
        .PACKET_SIZE     (PACKET_SIZE)
    ) u_word (
        .clk   (clk),
        .rst   (rst),
        .start (word_start),
        .word  (word_in),
        .active(word_active),
        .tx_bit(word_bit),
        .done  (word_done)
    );

    assign tx = tx_q;

    // word_active is implied by state_q == SEND; kept as a port for observability.
    logic unused_active;
    assign unused_active = word_active;

endmodule
